pipe_addsub: RTL and testbench

- Parametrised pipelined add/subtract unit; successor to the single-cycle combinational adder.
- Splits a WIDTH-bit add/sub into STAGES ripple chunks, one chunk per clock, with a valid/ready handshake.
- Reports carry-out and signed overflow, so the ALU/EX path can implement MIPS add/sub (trapping) and addu/subu (non-trapping).
- Sits between the operand-select muxes and EX/MEM writeback when the target clock rate cannot close a 32-bit carry chain in one cycle.

---
 rtl/pipe_addsub_pkg.sv | 10 +
 rtl/addsub_chunk.sv | 20 ++
 rtl/pipe_addsub.sv | 144 ++++++++++++++
 tb/tb_pipe_addsub.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// rtl/pipe_addsub_pkg.sv - shared constants for the pipelined add/sub unit
// Purpose: operation encodings and the default datapath width used by the ALU.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ALU_WIDTH = 32;

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CW-bit adder slice with carry in/out
// Purpose: one ripple chunk of the pipelined add/sub; the caller pre-inverts b for subtraction.
// Ports:
//   a, b  in  CW  chunk operands
//   cin   in  1   carry into the chunk LSB
//   sum   out CW  chunk sum
//   cout  out 1   carry out of the chunk MSB
module addsub_chunk #(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined WIDTH-bit add/subtract with valid/ready handshake
// Purpose: splits an add/sub into STAGES ripple chunks, one chunk per clock, and reports
//          carry-out and signed overflow for trapping and non-trapping add/sub.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                synchronous kill of every in-flight operation
//   in_valid/in_ready    operand handshake (a, b, sub)
//   out_valid/out_ready  result handshake (y, carry, ovf)
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES must be 1..8");
  end

  // Per-stage registers: full operands (b already conditionally inverted), the partial
  // result built so far, and the carry out of the most recently computed chunk.
  logic [STAGES-1:0]            s_valid;
  logic [STAGES-1:0][WIDTH-1:0] s_a;
  logic [STAGES-1:0][WIDTH-1:0] s_b;
  logic [STAGES-1:0][WIDTH-1:0] s_y;
  logic [STAGES-1:0]            s_c;
  logic                         ovf_r;

  // Stage inputs: stage 0 is fed from the ports, stage k from stage k-1.
  logic [STAGES-1:0][WIDTH-1:0] st_a;
  logic [STAGES-1:0][WIDTH-1:0] st_b;
  logic [STAGES-1:0][WIDTH-1:0] st_y;
  logic [STAGES-1:0]            st_c;
  logic [STAGES-1:0][WIDTH-1:0] nxt_y;

  logic [CW-1:0] ch_sum  [STAGES];
  logic          ch_cout [STAGES];

  // adv[k]: stage k's contents move on (or it is empty) this cycle, so it can accept.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              ovf_next;

  always_comb begin
    adv       = '0;
    adv[LAST] = out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !s_valid[k+1] || adv[k+1];
    end

    in_ready = !s_valid[0] || adv[0];
    load     = '0;
    load[0]  = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = s_valid[k-1] && adv[k-1];
    end

    st_a    = '0;
    st_b    = '0;
    st_y    = '0;
    st_c    = '0;
    st_a[0] = a;
    st_b[0] = (sub == OP_SUB) ? ~b : b;
    st_y[0] = '0;
    st_c[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = s_a[k-1];
      st_b[k] = s_b[k-1];
      st_y[k] = s_y[k-1];
      st_c[k] = s_c[k-1];
    end

    nxt_y = st_y;
    for (int k = 0; k < STAGES; k++) begin
      nxt_y[k][k*CW +: CW] = ch_sum[k];
    end

    // Overflow needs the operand sign bits, which travel with the data to the last stage.
    ovf_next = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
               (ch_sum[LAST][CW-1] != st_a[LAST][WIDTH-1]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    addsub_chunk #(.CW(CW)) u_chunk (
      .a    (st_a[k][k*CW +: CW]),
      .b    (st_b[k][k*CW +: CW]),
      .cin  (st_c[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= '0;
      s_a     <= '0;
      s_b     <= '0;
      s_y     <= '0;
      s_c     <= '0;
      ovf_r   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        // Flush wins over any load, including a same-cycle input handshake.
        if (flush) begin
          s_valid[k] <= 1'b0;
        end else begin
          s_valid[k] <= load[k] || (s_valid[k] && !adv[k]);
        end
        if (load[k]) begin
          s_a[k] <= st_a[k];
          s_b[k] <= st_b[k];
          s_y[k] <= nxt_y[k];
          s_c[k] <= ch_cout[k];
        end
      end
      if (load[LAST]) begin
        ovf_r <= ovf_next;
      end
    end
  end

  assign out_valid = s_valid[LAST];
  assign y         = s_y[LAST];
  assign carry     = s_c[LAST];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - scoreboard testbench for pipe_addsub at STAGES=2,1,4,8
module tb_pipe_addsub;
  import pipe_addsub_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  t_flush, t_in_valid, t_in_ready, t_sub, t_out_valid, t_out_ready, t_carry, t_ovf;
  logic [31:0] t_a [4];
  logic [31:0] t_b [4];
  logic [31:0] t_y [4];

  exp_t        q [4][$];
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          lat_exact = 1'b1;
  bit          stall_prev [4];
  logic [31:0] hold_y [4];
  logic        hold_c [4];
  logic        hold_o [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int ST = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 8;
    pipe_addsub #(.WIDTH(32), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (t_flush[i]),
      .in_valid  (t_in_valid[i]),
      .in_ready  (t_in_ready[i]),
      .a         (t_a[i]),
      .b         (t_b[i]),
      .sub       (t_sub[i]),
      .out_valid (t_out_valid[i]),
      .out_ready (t_out_ready[i]),
      .y         (t_y[i]),
      .carry     (t_carry[i]),
      .ovf       (t_ovf[i])
    );
  end

  function automatic int stages_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 8;
  endfunction

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic s, int t);
    exp_t        e;
    logic [31:0] bp;
    logic [32:0] full;
    bp   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {32'd0, s};
    e.y  = full[31:0];
    e.c  = full[32];
    e.o  = (a[31] == bp[31]) && (full[31] != a[31]);
    e.t  = t;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < 4; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Scoreboard monitor: pops on output handshakes, pushes on input handshakes.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        q[i].delete();
        stall_prev[i] = 1'b0;
      end else begin
        if (stall_prev[i]) begin
          n_assert++;
          assert (t_out_valid[i] === 1'b1 && t_y[i] === hold_y[i] &&
                  t_carry[i] === hold_c[i] && t_ovf[i] === hold_o[i])
          else begin
            n_fail++;
            $error("FAIL hold_stable inst%0d: v=%b y=%h c=%b o=%b required v=1 y=%h c=%b o=%b",
                   i, t_out_valid[i], t_y[i], t_carry[i], t_ovf[i], hold_y[i], hold_c[i], hold_o[i]);
          end
        end
        if (t_out_valid[i] && t_out_ready[i]) begin
          n_assert++;
          assert (q[i].size() > 0)
          else begin
            n_fail++;
            $error("FAIL unexpected_output inst%0d: got y=%h required no output", i, t_y[i]);
          end
          if (q[i].size() > 0) begin
            exp_t e;
            int   lat;
            e   = q[i].pop_front();
            lat = cyc - e.t;
            n_assert++;
            assert (t_y[i] === e.y)
            else begin n_fail++; $error("FAIL y inst%0d: got %h required %h", i, t_y[i], e.y); end
            n_assert++;
            assert (t_carry[i] === e.c)
            else begin n_fail++; $error("FAIL carry inst%0d: got %b required %b", i, t_carry[i], e.c); end
            n_assert++;
            assert (t_ovf[i] === e.o)
            else begin n_fail++; $error("FAIL ovf inst%0d: got %b required %b", i, t_ovf[i], e.o); end
            n_assert++;
            if (lat_exact) begin
              assert (lat == stages_of(i))
              else begin n_fail++; $error("FAIL latency inst%0d: got %0d required %0d", i, lat, stages_of(i)); end
            end else begin
              assert (lat >= stages_of(i))
              else begin n_fail++; $error("FAIL latency_min inst%0d: got %0d required >= %0d", i, lat, stages_of(i)); end
            end
          end
        end
        stall_prev[i] = t_out_valid[i] && !t_out_ready[i] && !t_flush[i];
        hold_y[i]     = t_y[i];
        hold_c[i]     = t_carry[i];
        hold_o[i]     = t_ovf[i];
        if (t_flush[i]) q[i].delete();
        else if (t_in_valid[i] && t_in_ready[i]) q[i].push_back(model(t_a[i], t_b[i], t_sub[i], cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int i, logic [31:0] a, logic [31:0] b, logic s);
    bit ok;
    t_a[i] = a;
    t_b[i] = b;
    t_sub[i] = s;
    t_in_valid[i] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (t_in_ready[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_assert++;
    assert (ok) else begin n_fail++; $error("FAIL send_timeout inst%0d: in_ready=0 required 1", i); end
    tick();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (all_empty()) begin
        ok = 1'b1;
        break;
      end
    end
    n_assert++;
    assert (ok) else begin n_fail++; $error("FAIL drain_timeout: results outstanding, required none"); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    t_flush = '0;
    t_in_valid = '0;
    t_sub = '0;
    t_out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      t_a[i] = '0;
      t_b[i] = '0;
    end

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      assert (t_out_valid[i] === 1'b0) else begin n_fail++; $error("FAIL rst_out_valid inst%0d: got %b required 0", i, t_out_valid[i]); end
      n_assert++;
      assert (t_y[i] === 32'd0) else begin n_fail++; $error("FAIL rst_y inst%0d: got %h required 0", i, t_y[i]); end
      n_assert++;
      assert (t_carry[i] === 1'b0 && t_ovf[i] === 1'b0) else begin n_fail++; $error("FAIL rst_flags inst%0d: got c=%b o=%b required 0 0", i, t_carry[i], t_ovf[i]); end
      n_assert++;
      assert (t_in_ready[i] === 1'b1) else begin n_fail++; $error("FAIL rst_in_ready inst%0d: got %b required 1", i, t_in_ready[i]); end
    end
    tick();

    // Single add with signed overflow.
    send(0, 32'h7FFF_FFFF, 32'h1, OP_ADD);
    t_in_valid[0] = 1'b0;
    drain();

    // Back-to-back stream.
    send(0, 32'h5, 32'h3, OP_ADD);
    send(0, 32'hFFFF_FFFF, 32'h1, OP_ADD);
    send(0, 32'h0, 32'h1, OP_SUB);
    send(0, 32'h8000_0000, 32'h1, OP_SUB);
    t_in_valid[0] = 1'b0;
    drain();

    // Backpressure mid-stream.
    lat_exact = 1'b0;
    send(0, 32'h5, 32'h3, OP_ADD);
    send(0, 32'hFFFF_FFFF, 32'h1, OP_ADD);
    t_a[0] = 32'h0;
    t_b[0] = 32'h1;
    t_sub[0] = OP_SUB;
    t_in_valid[0] = 1'b1;
    t_out_ready[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      assert (t_in_ready[0] === 1'b0) else begin n_fail++; $error("FAIL full_in_ready: got %b required 0", t_in_ready[0]); end
      tick();
    end
    t_out_ready[0] = 1'b1;
    send(0, 32'h0, 32'h1, OP_SUB);
    send(0, 32'h8000_0000, 32'h1, OP_SUB);
    t_in_valid[0] = 1'b0;
    drain();
    lat_exact = 1'b1;

    // Flush with a third input in the same cycle.
    send(0, 32'h11, 32'h22, OP_ADD);
    send(0, 32'h33, 32'h44, OP_SUB);
    t_a[0] = 32'h55;
    t_b[0] = 32'h66;
    t_sub[0] = OP_ADD;
    t_in_valid[0] = 1'b1;
    t_out_ready[0] = 1'b0;
    t_flush[0] = 1'b1;
    tick();
    t_flush[0] = 1'b0;
    t_in_valid[0] = 1'b0;
    t_out_ready[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_assert++;
      assert (t_out_valid[0] === 1'b0) else begin n_fail++; $error("FAIL flush_out_valid: got %b required 0", t_out_valid[0]); end
      tick();
    end
    // Flush on an empty pipeline drops the same-cycle input.
    t_a[0] = 32'h5;
    t_b[0] = 32'h6;
    t_in_valid[0] = 1'b1;
    t_flush[0] = 1'b1;
    tick();
    t_flush[0] = 1'b0;
    t_in_valid[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      assert (t_out_valid[0] === 1'b0) else begin n_fail++; $error("FAIL flush_drop: got %b required 0", t_out_valid[0]); end
      tick();
    end
    send(0, 32'h2, 32'h2, OP_ADD);
    t_in_valid[0] = 1'b0;
    drain();

    // Reset mid-operation.
    send(0, 32'h9, 32'h9, OP_ADD);
    t_in_valid[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    assert (t_out_valid[0] === 1'b0 && t_y[0] === 32'd0 && t_carry[0] === 1'b0 && t_ovf[0] === 1'b0)
    else begin n_fail++; $error("FAIL midop_rst: got v=%b y=%h c=%b o=%b required 0 0 0 0", t_out_valid[0], t_y[0], t_carry[0], t_ovf[0]); end
    tick();

    // Random sweep, unstalled: latency must be exact.
    for (int n = 0; n < 700; n++) begin
      for (int i = 0; i < 4; i++) begin
        t_in_valid[i] = ($urandom_range(0, 3) != 0);
        t_a[i] = pick();
        t_b[i] = pick();
        t_sub[i] = $urandom_range(0, 1);
      end
      tick();
    end
    t_in_valid = '0;
    drain();

    // Random sweep with random backpressure.
    lat_exact = 1'b0;
    for (int n = 0; n < 700; n++) begin
      for (int i = 0; i < 4; i++) begin
        t_in_valid[i] = ($urandom_range(0, 3) != 0);
        t_out_ready[i] = ($urandom_range(0, 2) != 0);
        t_a[i] = pick();
        t_b[i] = pick();
        t_sub[i] = $urandom_range(0, 1);
      end
      tick();
    end
    t_in_valid = '0;
    t_out_ready = '1;
    drain();

    n_assert++;
    assert (all_empty()) else begin n_fail++; $error("FAIL final_empty: results outstanding, required none"); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
